// File: rtl/gcd_pkg.sv
// Shared types and defaults for the GCD dispatcher: FSM states, operand-pair layout
// and the default width, queue depth and timeout.
package gcd_pkg;

    localparam int GCD_W       = 16;
    localparam int GCD_DEPTH   = 4;
    localparam int GCD_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } gcd_state_e;

    // Queue entries are packed {a, b}, with a in the upper half.
    typedef struct packed {
        logic [GCD_W-1:0] a;
        logic [GCD_W-1:0] b;
    } gcd_pair_t;

endpackage

// File: rtl/gcd_sync_fifo.sv
// Operand-pair FIFO with array storage and a registered head read, so the head
// becomes poppable one cycle after it is written (or after the previous pop).
module gcd_sync_fifo #(
    parameter int W2    = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   push,
    input  logic [W2-1:0]          push_data,
    input  logic                   pop,
    output logic [W2-1:0]          head_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

    logic [W2-1:0] mem [DEPTH];
    logic [W2-1:0] head_data_reg;
    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW:0]   count_reg, count_next;
    logic          head_valid_reg, head_valid_next;
    logic          full;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_reg == FULL_COUNT);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & head_valid_reg;

    always_comb begin
        wr_ptr_next     = wr_ptr_reg + PW'(push_ok);
        rd_ptr_next     = rd_ptr_reg + PW'(pop_ok);
        count_next      = count_reg + (PW + 1)'(push_ok) - (PW + 1)'(pop_ok);
        // The head register reloads every cycle; it is trustworthy only when the
        // entry at rd_ptr already existed before this edge and is not being popped.
        head_valid_next = (count_reg != '0) && !pop_ok;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            head_valid_reg <= 1'b0;
        end else begin
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            head_valid_reg <= head_valid_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        head_data_reg <= mem[rd_ptr_reg];
    end

    assign head_data = head_data_reg;
    assign count     = count_reg;
    // "empty" here means no head is ready to pop this cycle.
    assign empty     = ~head_valid_reg;

endmodule

// File: rtl/gcd_dispatch.sv
// Queued ready/valid wrapper around the GCDInner engine: buffers operand pairs,
// issues one job at a time with a load pulse and returns result, operands and timeout flag.
module gcd_dispatch
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = GCD_DEPTH,
    parameter int TIMEOUT = GCD_TIMEOUT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         io_in_valid,
    output logic         io_in_ready,
    input  logic [W-1:0] io_in_a,
    input  logic [W-1:0] io_in_b,
    output logic [W-1:0] io_eng_a,
    output logic [W-1:0] io_eng_b,
    output logic         io_eng_e,
    input  logic [W-1:0] io_eng_z,
    input  logic         io_eng_v,
    output logic         io_out_valid,
    input  logic         io_out_ready,
    output logic [W-1:0] io_out_z,
    output logic [W-1:0] io_out_a,
    output logic [W-1:0] io_out_b,
    output logic         io_out_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(DEPTH);
    localparam logic [TW-1:0]    WAIT_LIMIT = TW'(TIMEOUT);

    gcd_state_e   state_reg, state_next;
    logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [W-1:0] eng_a_reg, eng_a_next;
    logic [W-1:0] eng_b_reg, eng_b_next;
    logic         out_valid_reg, out_valid_next;
    logic [W-1:0] out_z_reg, out_z_next;
    logic [W-1:0] out_a_reg, out_a_next;
    logic [W-1:0] out_b_reg, out_b_next;
    logic         out_err_reg, out_err_next;

    logic [2*W-1:0]   fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;
    logic             load_head;

    // No pass-through when full: ready follows the registered count only.
    assign io_in_ready = (fifo_count != FIFO_FULL);
    assign fifo_push   = io_in_valid & io_in_ready;

    gcd_sync_fifo #(
        .W2   (2 * W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clock),
        .srst     (reset),
        .push     (fifo_push),
        .push_data({io_in_a, io_in_b}),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    always_comb begin
        state_next     = state_reg;
        wait_cnt_next  = wait_cnt_reg;
        eng_a_next     = eng_a_reg;
        eng_b_next     = eng_b_reg;
        out_valid_next = out_valid_reg;
        out_z_next     = out_z_reg;
        out_a_next     = out_a_reg;
        out_b_next     = out_b_reg;
        out_err_next   = out_err_reg;
        fifo_pop       = 1'b0;
        load_head      = 1'b0;

        case (state_reg)
            IDLE: begin
                load_head = ~fifo_empty;
            end
            ISSUE: begin
                state_next    = WAIT;
                wait_cnt_next = '0;
            end
            WAIT: begin
                // io_eng_v is only trusted here; in ISSUE it may still be the previous job's.
                if (io_eng_v) begin
                    out_z_next     = io_eng_z;
                    out_err_next   = 1'b0;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end else if (wait_cnt_reg == WAIT_LIMIT) begin
                    out_z_next     = '0;
                    out_err_next   = 1'b1;
                    out_valid_next = 1'b1;
                    state_next     = HOLD;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TW'(1);
                end
            end
            HOLD: begin
                if (io_out_ready) begin
                    out_valid_next = 1'b0;
                    load_head      = ~fifo_empty;
                    state_next     = fifo_empty ? IDLE : HOLD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load_head) begin
            fifo_pop   = 1'b1;
            state_next = ISSUE;
            eng_a_next = fifo_head[2*W-1:W];
            eng_b_next = fifo_head[W-1:0];
            out_a_next = fifo_head[2*W-1:W];
            out_b_next = fifo_head[W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            wait_cnt_reg  <= '0;
            eng_a_reg     <= '0;
            eng_b_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_z_reg     <= '0;
            out_a_reg     <= '0;
            out_b_reg     <= '0;
            out_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            eng_a_reg     <= eng_a_next;
            eng_b_reg     <= eng_b_next;
            out_valid_reg <= out_valid_next;
            out_z_reg     <= out_z_next;
            out_a_reg     <= out_a_next;
            out_b_reg     <= out_b_next;
            out_err_reg   <= out_err_next;
        end
    end

    assign io_eng_a     = eng_a_reg;
    assign io_eng_b     = eng_b_reg;
    assign io_eng_e     = (state_reg == ISSUE);
    assign io_out_valid = out_valid_reg;
    assign io_out_z     = out_z_reg;
    assign io_out_a     = out_a_reg;
    assign io_out_b     = out_b_reg;
    assign io_out_err   = out_err_reg;

endmodule
